// File: rtl/uart_tx_word_ctrl_if.sv
// FIFO read port and UART TX core handshake bundle for the word-to-chunk controller.
// The master modport is the controller side; the slave modport is the FIFO/UART side.
interface uart_tx_word_ctrl_if #(
  parameter int UART_FIFO_WIDTH = 32,
  parameter int UART_DATA_WIDTH = 8
);
  logic                       f_empty;
  logic [UART_FIFO_WIDTH-1:0] fifo_read_data;
  logic                       fifo_read_en;
  logic                       uart_tx_done;
  logic                       uart_dv;
  logic [UART_DATA_WIDTH-1:0] uart_data;

  modport master (
    input  f_empty, fifo_read_data, uart_tx_done,
    output fifo_read_en, uart_dv, uart_data
  );

  modport slave (
    output f_empty, fifo_read_data, uart_tx_done,
    input  fifo_read_en, uart_dv, uart_data
  );
endinterface

// File: rtl/uart_tx_word_ctrl.sv
// Pops words from the TX FIFO and hands them to the UART TX core one chunk at a time,
// with per-chunk dv/done handshaking, selectable chunk order and a done watchdog.
module uart_tx_word_ctrl #(
  parameter int UART_FIFO_WIDTH = 32,
  parameter int UART_DATA_WIDTH = 8,
  parameter int FIFO_RD_LATENCY = 1,
  parameter int MSB_FIRST       = 0,
  parameter int DONE_TIMEOUT    = 0,
  parameter int TIMEOUT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  uart_tx_word_ctrl_if.master bus,
  output logic                busy,
  output logic                timeout_err,
  output logic [15:0]         tx_count
);
  localparam int FW     = UART_FIFO_WIDTH;
  localparam int DW     = UART_DATA_WIDTH;
  localparam int NCHUNK = FW / DW;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(NCHUNK - 1);
  localparam logic [1:0]           LAT_LAST     = (FIFO_RD_LATENCY > 0) ? 2'(FIFO_RD_LATENCY - 1) : 2'd0;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = (DONE_TIMEOUT > 0) ? TIMEOUT_W'(DONE_TIMEOUT - 1)
                                                                     : {TIMEOUT_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    LOAD      = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [FW-1:0]        sr_r, sr_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [1:0]           lat_r, lat_s;
  logic [TIMEOUT_W-1:0] wd_r, wd_s;
  logic [15:0]          cnt_r, cnt_s;
  logic                 expire_s;

  logic          rd_en_r, rd_en_s;
  logic          dv_r, dv_s;
  logic [DW-1:0] data_r, data_s;
  logic          busy_r, busy_s;
  logic          terr_r, terr_s;

  // The chunk on deck always sits at the leading end of the shift register.
  function automatic logic [DW-1:0] head_chunk(input logic [FW-1:0] w);
    if (MSB_FIRST != 0) begin
      head_chunk = w[FW-1 -: DW];
    end else begin
      head_chunk = w[DW-1:0];
    end
  endfunction

  function automatic logic [FW-1:0] shift_out(input logic [FW-1:0] w);
    if (MSB_FIRST != 0) begin
      shift_out = w << DW;
    end else begin
      shift_out = w >> DW;
    end
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sr_r    <= {FW{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      lat_r   <= 2'd0;
      wd_r    <= {TIMEOUT_W{1'b0}};
      cnt_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      sr_r    <= sr_s;
      idx_r   <= idx_s;
      lat_r   <= lat_s;
      wd_r    <= wd_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_s  = state_r;
    sr_s     = sr_r;
    idx_s    = idx_r;
    lat_s    = lat_r;
    wd_s     = wd_r;
    cnt_s    = cnt_r;
    expire_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && !bus.f_empty) begin
          state_s = READ;
          lat_s   = 2'd0;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        // First-word-fall-through data is already valid in the pop cycle.
        if (FIFO_RD_LATENCY == 0) begin
          sr_s    = bus.fifo_read_data;
          idx_s   = {IDX_W{1'b0}};
          state_s = SEND;
        end else if (lat_r == LAT_LAST) begin
          state_s = LOAD;
        end else begin
          lat_s = lat_r + 2'd1;
        end
      end
      LOAD: begin
        sr_s    = bus.fifo_read_data;
        idx_s   = {IDX_W{1'b0}};
        state_s = SEND;
      end
      SEND: begin
        wd_s    = {TIMEOUT_W{1'b0}};
        state_s = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.uart_tx_done) begin
          cnt_s = cnt_r + 16'd1;
          if (idx_r != IDX_LAST) begin
            idx_s   = idx_r + IDX_W'(1);
            sr_s    = shift_out(sr_r);
            state_s = SEND;
          end else if (enable && !bus.f_empty) begin
            lat_s   = 2'd0;
            state_s = READ;
          end else begin
            state_s = IDLE;
          end
        end else if ((DONE_TIMEOUT != 0) && (wd_r == TIMEOUT_LAST)) begin
          expire_s = 1'b1;
          state_s  = IDLE;
        end else begin
          wd_s = wd_r + TIMEOUT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered
  always_comb begin
    rd_en_s = (state_s == READ) && (state_r != READ);
    dv_s    = (state_s == SEND);
    busy_s  = (state_s != IDLE);
    terr_s  = expire_s;
    if (dv_s) begin
      data_s = head_chunk(sr_s);
    end else begin
      data_s = {DW{1'b0}};
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_r <= 1'b0;
      dv_r    <= 1'b0;
      data_r  <= {DW{1'b0}};
      busy_r  <= 1'b0;
      terr_r  <= 1'b0;
    end else begin
      rd_en_r <= rd_en_s;
      dv_r    <= dv_s;
      data_r  <= data_s;
      busy_r  <= busy_s;
      terr_r  <= terr_s;
    end
  end

  assign bus.fifo_read_en = rd_en_r;
  assign bus.uart_dv      = dv_r;
  assign bus.uart_data    = data_r;
  assign busy             = busy_r;
  assign timeout_err      = terr_r;
  assign tx_count         = cnt_r;
endmodule
